// File: rtl/alu_seq.sv
// Multi-cycle ALU: logical/shift/rotate/add/sub finish in one cycle; signed
// multiply (shift-add) and divide (restoring) iterate one bit per cycle.
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [4:0]         op_code,
    input  logic [WIDTH-1:0]   in_A,
    input  logic [WIDTH-1:0]   in_B,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done,
    output logic               zero,
    output logic               div_zero,
    output logic               illegal_op,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_NEG  = 5'b00011;
    localparam logic [4:0] OP_NOT  = 5'b00100;
    localparam logic [4:0] OP_SHL  = 5'b00101;
    localparam logic [4:0] OP_SHR  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ADD  = 5'b01010;
    localparam logic [4:0] OP_SUB  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;

    // Handshake: start is sampled on a rising edge only while busy=0; done
    // pulses for one cycle whenever out and the flags are updated.
    logic [1:0]         state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic               div_zero_q, div_zero_d;
    logic               illegal_q, illegal_d;

    logic [SHW-1:0]     sh;
    logic               big_sh;
    logic [SHW-1:0]     idx_l, idx_r;
    logic [WIDTH-1:0]   rol_v, ror_v;
    logic [WIDTH-1:0]   sc_lo;
    logic               sc_illegal;
    logic               is_iter;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] fin_res;
    logic [2*WIDTH-1:0] prod;

    assign sh      = in_B[SHW-1:0];
    assign big_sh  = |in_B[WIDTH-1:SHW];
    assign is_iter = (op_code == OP_MUL) || (op_code == OP_DIV);
    assign a_abs   = in_A[WIDTH-1] ? -in_A : in_A;
    assign b_abs   = in_B[WIDTH-1] ? -in_B : in_B;

    always_comb begin
        rol_v = '0;
        ror_v = '0;
        idx_l = '0;
        idx_r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx_l    = SHW'(i) - sh;
            idx_r    = SHW'(i) + sh;
            rol_v[i] = in_A[idx_l];
            ror_v[i] = in_A[idx_r];
        end
    end

    always_comb begin
        sc_lo      = '0;
        sc_illegal = 1'b0;
        case (op_code)
            OP_OR:   sc_lo = in_A | in_B;
            OP_AND:  sc_lo = in_A & in_B;
            OP_NEG:  sc_lo = -in_B;
            OP_NOT:  sc_lo = ~in_B;
            OP_SHL:  sc_lo = big_sh ? '0 : (in_A << sh);
            OP_SHR:  sc_lo = big_sh ? '0 : (in_A >> sh);
            OP_SHRA: sc_lo = big_sh ? {WIDTH{in_A[WIDTH-1]}} : ($signed(in_A) >>> sh);
            OP_ROL:  sc_lo = rol_v;
            OP_ROR:  sc_lo = ror_v;
            OP_ADD:  sc_lo = in_A + in_B;
            OP_SUB:  sc_lo = in_A - in_B;
            OP_MUL, OP_DIV: sc_lo = '0;
            default: sc_illegal = 1'b1;
        endcase
    end

    // Multiply shifts {hi,lo} right with lo preloaded by |B|; divide shifts
    // the dividend (lo) into the partial remainder (hi) MSB first.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;
    assign prod      = {hi_q, lo_q};

    always_comb begin
        fin_res = neg_lo_q ? -prod : prod;
        if (is_div_q) begin
            if (b_q == '0) begin
                fin_res = {(neg_hi_q ? -a_q : a_q), {WIDTH{1'b1}}};
            end else begin
                fin_res = {(neg_hi_q ? -hi_q : hi_q), (neg_lo_q ? -lo_q : lo_q)};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        out_d      = out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        zero_d     = zero_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_iter) begin
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        is_div_d = (op_code == OP_DIV);
                        neg_lo_d = in_A[WIDTH-1] ^ in_B[WIDTH-1];
                        neg_hi_d = in_A[WIDTH-1];
                        a_d      = a_abs;
                        b_d      = b_abs;
                        hi_d     = '0;
                        lo_d     = (op_code == OP_DIV) ? a_abs : b_abs;
                    end else begin
                        out_d      = {{WIDTH{1'b0}}, sc_lo};
                        zero_d     = (sc_lo == '0);
                        div_zero_d = 1'b0;
                        illegal_d  = sc_illegal;
                        done_d     = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                out_d      = fin_res;
                zero_d     = (fin_res == '0);
                div_zero_d = is_div_q && (b_q == '0);
                illegal_d  = 1'b0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            zero_q     <= zero_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
        end
    end

    assign out        = out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign zero       = zero_q;
    assign div_zero   = div_zero_q;
    assign illegal_op = illegal_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expected results.
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_SHL  = 5'b00101;
    localparam logic [4:0] OP_SHR  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ADD  = 5'b01010;
    localparam logic [4:0] OP_SUB  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00010;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [4:0]     op_code;
    logic [W-1:0]   in_A;
    logic [W-1:0]   in_B;
    logic [2*W-1:0] out;
    logic           busy;
    logic           done;
    logic           zero;
    logic           div_zero;
    logic           illegal_op;
    logic [1:0]     dbg_state;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op_code    (op_code),
        .in_A       (in_A),
        .in_B       (in_B),
        .out        (out),
        .busy       (busy),
        .done       (done),
        .zero       (zero),
        .div_zero   (div_zero),
        .illegal_op (illegal_op),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start   = 1'b1;
        op_code = op;
        in_A    = a;
        in_B    = b;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // scoreboard
    task automatic sb_check(input string tag);
        logic [2*W-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, out, e);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp, input int exp_lat);
        int lat;
        exp_q.push_back(exp);
        issue(op, a, b);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        sb_check(tag);
    endtask

    initial begin
        int lat;
        int busy_cycles;
        logic [2*W-1:0] held;

        reset_n = 1'b0;
        start   = 1'b0;
        op_code = '0;
        in_A    = '0;
        in_B    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 64'h0);
        check("rst_flags", {60'h0, busy, done, zero, div_zero}, 64'h0);
        check("rst_illegal", 64'(illegal_op), 64'h0);
        check("rst_state", 64'(dbg_state), 64'h0);

        // release then start on the very next rising edge
        @(negedge clk);
        reset_n = 1'b1;
        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 64'h0000_0000_8000_0000, 0);
        check("add_busy", 64'(busy), 64'h0);
        check("add_zero", 64'(zero), 64'h0);
        held = out;
        tick();
        check("done_pulse", 64'(done), 64'h0);
        check("out_held", out, held);

        run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 64'h0, 0);
        check("sub_zflag", 64'(zero), 64'h1);
        run_op("shra_big", OP_SHRA, 32'h8000_0000, 32'd40, 64'h0000_0000_FFFF_FFFF, 0);
        run_op("shl_big", OP_SHL, 32'h8000_0000, 32'd40, 64'h0, 0);
        run_op("shr_4", OP_SHR, 32'hF000_0000, 32'd4, 64'h0000_0000_0F00_0000, 0);
        run_op("rol_33", OP_ROL, 32'h8000_0001, 32'd33, 64'h0000_0000_0000_0003, 0);
        run_op("ror_4", OP_ROR, 32'h0000_0001, 32'd4, 64'h0000_0000_1000_0000, 0);
        run_op("neg_5", OP_NEG, 32'h0, 32'd5, 64'h0000_0000_FFFF_FFFB, 0);
        run_op("and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 64'h0000_0000_0F00_0F00, 0);

        // MUL with a start pulsed mid-run that must be ignored
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd7);
        busy_cycles = 0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cycles++;
            if (lat == 5) check("mul_state_run", 64'(dbg_state), 64'h1);
            start   = (lat == 5);
            op_code = OP_ADD;
            in_A    = 32'd1;
            in_B    = 32'd1;
            tick();
            lat++;
        end
        start = 1'b0;
        check("mul_busy_cycles", 64'(busy_cycles), 64'd33);
        check("mul_lat", 64'(lat), 64'd33);
        check("mul_busy_at_done", 64'(busy), 64'h0);
        sb_check("mul_neg");
        tick();
        check("mul_no_queued_start", 64'(done), 64'h0);

        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        check("div_neg_dz", 64'(div_zero), 64'h0);
        // back-to-back: issued in the cycle done is high
        run_op("div_by0", OP_DIV, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 33);
        check("div_by0_dz", 64'(div_zero), 64'h1);
        run_op("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);
        check("div_min_dz", 64'(div_zero), 64'h0);

        // asynchronous reset at iteration 10 of a multiply
        issue(OP_MUL, 32'd1234, 32'd5678);
        repeat (10) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out", out, 64'h0);
        check("arst_busy_done", {62'h0, busy, done}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("add_after_rst", OP_ADD, 32'd2, 32'd2, 64'h4, 0);

        run_op("illegal", 5'b11111, 32'h1234, 32'h5678, 64'h0, 0);
        check("illegal_flag", 64'(illegal_op), 64'h1);
        run_op("or_clear", OP_OR, 32'h0000_00F0, 32'h0000_000F, 64'h0000_0000_0000_00FF, 0);
        check("or_illegal_clr", 64'(illegal_op), 64'h0);
        run_op("add_b2b", OP_ADD, 32'd3, 32'd4, 64'h7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Same 5-bit op_code map. Operands are latched on a start handshake.
- Logical, shift, rotate, add and sub complete in one cycle. Multiply (shift-add) and divide (restoring) iterate one bit per cycle.
- Result is a registered 2*WIDTH word held for the HI/LO registers. Status flags are exposed for the control unit.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift/rotate amount width (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op_code  in  5  operation select; latched on accepted start.
- in_A  in  WIDTH  operand A; latched on accepted start.
- in_B  in  WIDTH  operand B; latched on accepted start.
- out  out  2*WIDTH  registered result; [WIDTH-1:0]=LO, [2*WIDTH-1:WIDTH]=HI.
- busy  out  1  high while an iterative op is running.
- done  out  1  one-cycle pulse when out is updated.
- zero  out  1  out==0; updated with out.
- div_zero  out  1  last op was DIV with B==0; updated with out.
- illegal_op  out  1  last op_code was unmapped; updated with out.

Behaviour:
- Reset (async, reset_n=0):
  - out=0; busy, done, zero, div_zero, illegal_op=0. Note zero=0 in reset despite out=0.
  - FSM returns to IDLE and any in-flight op is discarded.
  - First start is accepted on the first rising edge after deassertion.
- FSM states: IDLE, RUN, FINISH.
  - IDLE, start=1 with single-cycle or unmapped op: compute from live inputs, register out and flags, done=1 next cycle; stay IDLE. Latency 1.
  - IDLE, start=1 with MUL (01100) or DIV (01101): latch |A| and |B| and result signs; clear counter; busy=1; go to RUN.
  - RUN: one iteration per edge; counter 0..WIDTH-1; after WIDTH iterations go to FINISH.
  - FINISH: apply sign correction, register out and flags, done=1, busy=0; go to IDLE.
  - Iterative latency: start edge k gives done high in the cycle following edge k+WIDTH+1.
  - start while busy=1 is ignored, not queued. start in the same cycle done is high is accepted (back-to-back).
- Op map (LO result, HI=0 unless noted):
  - 00001 OR; 00010 AND; 00011 NEG = -B (two's complement); 00100 NOT = ~B.
  - 00101 SHL A<<B; 00110 SHR A>>B (logical); 00111 SHRA A>>>B (sign fill).
  - 01000 ROL A by B mod WIDTH; 01001 ROR A by B mod WIDTH.
  - 01010 ADD A+B mod 2^WIDTH; 01011 SUB A-B mod 2^WIDTH.
  - 01100 MUL: signed A*B, full 2*WIDTH product in {HI,LO}.
  - 01101 DIV: signed A/B, LO=quotient truncated toward zero, HI=remainder with the sign of A.
  - Other codes: out=0, illegal_op=1.
- Shift boundaries:
  - B >= WIDTH (full B compared): SHL and SHR give 0; SHRA gives all copies of A[WIDTH-1].
  - Rotates use B[SHW-1:0] only.
- Divide boundaries:
  - B==0: LO=all ones, HI=A, div_zero=1; still takes the full iterative latency.
  - A=MIN, B=-1: LO=MIN, HI=0, no flag.
- out and flags are held stable between done pulses. done is never high while busy=1.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1 → out=0x0000_0000_8000_0000, done 1 cycle after start, busy stays 0. SUB 5-5 → out=0, zero=1.
- SHRA A=0x80000000, B=40 → LO=0xFFFFFFFF. SHL same B → 0. ROL A=0x80000001, B=33 → LO=0x00000003.
- MUL -3*7 → out=0xFFFFFFFF_FFFFFFEB. Check busy for 33 cycles, done exactly at cycle 33, and that a start pulsed mid-run is ignored.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 9/0 → LO=0xFFFFFFFF, HI=9, div_zero=1. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- Assert reset_n=0 asynchronously mid-MUL at iteration 10 → out=0, busy=0, done=0 immediately. A new ADD 2+2 after release → LO=4 in 1 cycle.
- op_code 11111 → out=0, illegal_op=1, done pulse. Next OR 0xF0|0x0F clears illegal_op and gives LO=0xFF. Back-to-back start on the done cycle is accepted.
